// File: rtl/udma_filter_pkg.sv
// udma_filter_pkg: filter cfg-port register map and sequencer state encoding
package udma_filter_pkg;
  localparam logic [4:0] REG_BINCU_CNT = 5'h15;
  localparam logic [4:0] REG_START     = 5'h17;
  localparam logic [4:0] REG_DONE      = 5'h18;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_START,
    S_GAP,
    S_POLL,
    S_RDCNT,
    S_CLR
  } state_e;
endpackage

// File: rtl/udma_filter_poll_timer.sv
// udma_filter_poll_timer: inter-poll gap down-counter and saturating poll counter with timeout match
module udma_filter_poll_timer #(
  parameter int POLL_GAP  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 reload_i,
  input  logic                 dec_i,
  input  logic                 inc_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 gap_zero_o,
  output logic                 tmo_o
);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
  logic [GW-1:0]        gap_q;
  logic [TIMEOUT_W-1:0] poll_q, poll_inc;
  assign poll_inc   = &poll_q ? poll_q : poll_q + 1'b1;
  assign gap_zero_o = gap_q == '0;
  // match on the count this poll would produce, so the deciding poll is the last one
  assign tmo_o      = timeout_i != '0 && poll_inc == timeout_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_q  <= '0;
      poll_q <= '0;
    end else begin
      gap_q  <= (load_i || reload_i) ? GAP_LOAD : (dec_i && !gap_zero_o) ? gap_q - 1'b1 : gap_q;
      poll_q <= load_i ? '0 : inc_i ? poll_inc : poll_q;
    end
  end
endmodule

// File: rtl/udma_filter_cfg_seq.sv
// udma_filter_cfg_seq: cfg-bus initiator that writes a command list, starts the filter, polls done and reads the result
module udma_filter_cfg_seq
  import udma_filter_pkg::*;
#(
  parameter int TRANS_SIZE = 15,
  parameter int POLL_GAP   = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [4:0]            cmd_addr_i,
  input  logic [31:0]           cmd_data_i,
  input  logic                  cmd_last_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  input  logic                  abort_i,
  output logic                  cfg_valid_o,
  output logic                  cfg_rwn_o,
  output logic [4:0]            cfg_addr_o,
  output logic [31:0]           cfg_data_o,
  input  logic                  cfg_ready_i,
  input  logic [31:0]           cfg_data_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic                  job_err_o,
  output logic [TRANS_SIZE-1:0] result_o
);
  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [TRANS_SIZE-1:0] result_q;
  logic                  res_we, load, reload, dec, inc, gap_zero, tmo;
  logic                  unused_cfg_data;
  assign unused_cfg_data = ^cfg_data_i;
  assign busy_o   = state_q != S_IDLE;
  assign result_o = result_q;
  udma_filter_poll_timer #(
    .POLL_GAP (POLL_GAP),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .reload_i  (reload),
    .dec_i     (dec),
    .inc_i     (inc),
    .timeout_i (timeout_i),
    .gap_zero_o(gap_zero),
    .tmo_o     (tmo)
  );
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    cfg_valid_o = 1'b0;
    cfg_rwn_o   = 1'b0;
    cfg_addr_o  = '0;
    cfg_data_o  = '0;
    job_done_o  = 1'b0;
    job_err_o   = 1'b0;
    res_we      = 1'b0;
    load        = 1'b0;
    reload      = 1'b0;
    dec         = 1'b0;
    inc         = 1'b0;
    case (state_q)
      S_IDLE: state_d = cmd_valid_i ? S_WR : S_IDLE;
      S_WR: begin
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_CLR;
        end else begin
          cfg_valid_o = cmd_valid_i;
          cfg_addr_o  = cmd_addr_i;
          cfg_data_o  = cmd_data_i;
          cmd_ready_o = cfg_ready_i;
          if (cmd_valid_i && cfg_ready_i && cmd_last_i) state_d = S_START;
        end
      end
      // aborts here are latched in err and acted on only once the presented transfer is accepted
      S_START: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_START;
        cfg_data_o  = 32'h1;
        err_d       = err_q | abort_i;
        if (cfg_ready_i) begin
          load    = 1'b1;
          state_d = err_d ? S_CLR : S_GAP;
        end
      end
      S_GAP: begin
        dec     = 1'b1;
        err_d   = err_q | abort_i;
        state_d = err_d ? S_CLR : gap_zero ? S_POLL : S_GAP;
      end
      S_POLL: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = REG_DONE;
        err_d       = err_q | abort_i;
        if (cfg_ready_i) begin
          inc = !cfg_data_i[0];
          if (err_d) state_d = S_CLR;
          else if (cfg_data_i[0]) state_d = S_RDCNT;
          else if (tmo) begin
            err_d   = 1'b1;
            state_d = S_CLR;
          end else begin
            reload  = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_RDCNT: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = REG_BINCU_CNT;
        err_d       = err_q | abort_i;
        if (cfg_ready_i) begin
          res_we  = !err_d;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = REG_DONE;
        cfg_data_o  = 32'h1;
        if (cfg_ready_i) begin
          job_err_o  = err_q;
          job_done_o = !err_q;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      result_q <= res_we ? cfg_data_i[TRANS_SIZE-1:0] : result_q;
    end
  end
endmodule

// File: tb/tb_udma_filter_cfg_seq.sv
// tb_udma_filter_cfg_seq: randomized scoreboard bench with a behavioural cfg slave for udma_filter_cfg_seq
module tb_udma_filter_cfg_seq;
  import udma_filter_pkg::*;
  localparam int TS = 15;
  localparam int PG = 8;
  localparam int TW = 16;
  localparam int NEVER = 1 << 30;
  logic clk_i = 1'b0;
  logic rst_i, cmd_valid_i, cmd_ready_o, cmd_last_i, abort_i;
  logic [4:0] cmd_addr_i, cfg_addr_o;
  logic [31:0] cmd_data_i, cfg_data_o, cfg_data_i;
  logic [TW-1:0] timeout_i;
  logic cfg_valid_o, cfg_rwn_o, cfg_ready_i, busy_o, job_done_o, job_err_o;
  logic [TS-1:0] result_o;
  udma_filter_cfg_seq #(.TRANS_SIZE(TS), .POLL_GAP(PG), .TIMEOUT_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_last_i(cmd_last_i),
    .timeout_i(timeout_i), .abort_i(abort_i), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
    .cfg_data_i(cfg_data_i), .busy_o(busy_o), .job_done_o(job_done_o), .job_err_o(job_err_o),
    .result_o(result_o)
  );
  always #5 clk_i = ~clk_i;
  // kind: 0 single transfer, 1 polls until done read, 2 polls until limit, 3 polls until the clear write
  typedef struct {int kind; logic rwn; logic [4:0] addr; logic [31:0] data; int limit;} exp_t;
  typedef struct {logic err; logic [TS-1:0] res;} out_t;
  exp_t exp_q[$];
  out_t out_q[$];
  int checks = 0, failures = 0;
  int ncyc = 0, polls = 0, last_acc = 0, rdy_mode = 0, done_delay = NEVER, scyc = 0, start_cyc = 0;
  logic pend_prev = 0, prev_stall = 0, busy_chk = 0, start_seen = 0, started = 0, done_flag;
  logic [38:0] prev_tx = '0;
  logic [31:0] bincu_val = 0;
  logic [TS-1:0] last_res = '0;
  logic [4:0] cmd_a[8];
  logic [31:0] cmd_d[8];
  // slave: done becomes sticky done_delay cycles after START, cleared by writing DONE; data is junk unless accepted
  assign done_flag = started && (scyc - start_cyc >= done_delay);
  assign cfg_data_i = !cfg_ready_i ? 32'hFFFF_FFFF : cfg_addr_o == REG_DONE ? {31'b0, done_flag} :
                      cfg_addr_o == REG_BINCU_CNT ? bincu_val : 32'hDEAD_BEEF;
  always @(posedge clk_i) begin
    scyc <= scyc + 1;
    if (rst_i) started <= 1'b0;
    else if (cfg_valid_o && cfg_ready_i && !cfg_rwn_o && cfg_addr_o == REG_START) begin
      started   <= 1'b1;
      start_cyc <= scyc;
    end else if (cfg_valid_o && cfg_ready_i && !cfg_rwn_o && cfg_addr_o == REG_DONE) started <= 1'b0;
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask
  task automatic on_txn();
    exp_t e;
    if (exp_q.size() == 0) check("unexpected_txn", 64'(1), 64'(0));
    else if (exp_q[0].kind != 0 && !(exp_q[0].kind == 3 && !cfg_rwn_o)) begin
      check("poll_txn", 64'({cfg_rwn_o, cfg_addr_o}), 64'({1'b1, REG_DONE}));
      polls++;
      last_acc = ncyc;
      if (exp_q[0].kind == 1 && cfg_data_i[0]) begin
        if (exp_q[0].limit >= 0) check("poll_count", 64'(polls), 64'(exp_q[0].limit));
        e = exp_q.pop_front();
      end else if (exp_q[0].kind == 2 && polls == exp_q[0].limit) e = exp_q.pop_front();
    end else begin
      if (exp_q[0].kind == 3) begin
        check("abort_polls", 64'(polls), 64'(exp_q[0].limit));
        e = exp_q.pop_front();
      end
      if (exp_q.size() == 0) check("unexpected_txn", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("txn", 64'({cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? 32'h0 : cfg_data_o}), 64'({e.rwn, e.addr, e.data}));
        if (!cfg_rwn_o && cfg_addr_o == REG_START) begin
          polls = 0;
          last_acc = ncyc;
          start_seen = 1'b1;
        end
      end
    end
  endtask
  task automatic on_pulse();
    out_t o;
    if (out_q.size() == 0) check("unexpected_pulse", 64'(1), 64'(0));
    else begin
      o = out_q.pop_front();
      check("job_pulse", 64'({job_done_o, job_err_o}), 64'({!o.err, o.err}));
      check("result", 64'(result_o), 64'(o.res));
      check("busy_at_end", 64'(busy_o), 64'(1));
    end
    busy_chk = 1'b1;
  endtask
  initial begin
    logic pres;
    forever begin
      @(negedge clk_i);
      ncyc++;
      if (rst_i) begin
        pend_prev = 0;
        prev_stall = 0;
        busy_chk = 0;
      end else begin
        if (prev_stall) check("hold", 64'({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}), 64'(prev_tx));
        prev_stall = cfg_valid_o && !cfg_ready_i;
        prev_tx = {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o};
        pres = cfg_valid_o && cfg_rwn_o && cfg_addr_o == REG_DONE;
        if (pres && !pend_prev) check("poll_gap", 64'(ncyc - last_acc), 64'(PG + 1));
        pend_prev = pres && !cfg_ready_i;
        if (cfg_valid_o && cfg_ready_i) on_txn();
        if (busy_chk) begin
          check("busy_fall", 64'(busy_o), 64'(0));
          busy_chk = 0;
        end
        if (job_done_o || job_err_o) on_pulse();
      end
    end
  end
  initial begin
    cfg_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      cfg_ready_i = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : rdy_mode == 2 ? ~cfg_ready_i : 1'b0;
    end
  end
  task automatic rand_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_a[i] = 5'($urandom_range(0, 20));
      cmd_d[i] = $urandom;
    end
  endtask
  task automatic send_cmd(input logic [4:0] a, input logic [31:0] d, input logic l);
    logic acc = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i = a;
    cmd_data_i = d;
    cmd_last_i = l;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk_i);
      acc = cmd_ready_o;
      @(posedge clk_i);
      #1;
    end
    if (!acc) check("cmd_accept", 64'(0), 64'(1));
    cmd_valid_i = 1'b0;
    cmd_last_i = 1'b0;
  endtask
  task automatic run_job(input int n, input int delay, input int tmo, input int mode,
                         input int bubble_at, input bit do_abort, input bit do_reset);
    done_delay = delay;
    timeout_i = TW'(tmo);
    rdy_mode = mode;
    start_seen = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back('{0, 1'b0, cmd_a[i], cmd_d[i], 0});
    exp_q.push_back('{0, 1'b0, REG_START, 32'h1, 0});
    if (do_abort) exp_q.push_back('{3, 1'b1, REG_DONE, 32'h0, 1});
    else if (delay == NEVER) exp_q.push_back('{2, 1'b1, REG_DONE, 32'h0, tmo});
    else begin
      exp_q.push_back('{1, 1'b1, REG_DONE, 32'h0, delay == 0 ? 1 : -1});
      exp_q.push_back('{0, 1'b1, REG_BINCU_CNT, 32'h0, 0});
    end
    exp_q.push_back('{0, 1'b0, REG_DONE, 32'h1, 0});
    if (do_abort || delay == NEVER) out_q.push_back('{1'b1, last_res});
    else begin
      last_res = bincu_val[TS-1:0];
      out_q.push_back('{1'b0, last_res});
    end
    for (int i = 0; i < n; i++) begin
      if (i == bubble_at)
        for (int b = 0; b < 5; b++) begin
          @(negedge clk_i);
          check("bubble", 64'(cfg_valid_o), 64'(0));
          @(posedge clk_i);
          #1;
        end
      send_cmd(cmd_a[i], cmd_d[i], i == n - 1);
    end
    if (do_abort) begin
      for (int k = 0; k < 100 && !start_seen; k++) @(negedge clk_i);
      rdy_mode = 3;
      for (int k = 0; k < 100 && !(cfg_valid_o && cfg_rwn_o); k++) @(negedge clk_i);
      @(posedge clk_i);
      #1;
      abort_i = 1'b1;
      rdy_mode = 0;
      @(posedge clk_i);
      #1;
      abort_i = 1'b0;
    end
    if (do_reset) begin
      for (int k = 0; k < 100 && !(cfg_valid_o && cfg_rwn_o); k++) @(negedge clk_i);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      check("rst_outs", 64'({cfg_valid_o, cmd_ready_o, busy_o, job_done_o, job_err_o, cfg_rwn_o, cfg_addr_o}), 64'(0));
      check("rst_result", 64'(result_o), 64'(0));
      exp_q.delete();
      out_q.delete();
      last_res = '0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
    end else begin
      for (int k = 0; k < 4000 && (exp_q.size() != 0 || out_q.size() != 0); k++) @(negedge clk_i);
      if (exp_q.size() != 0 || out_q.size() != 0) begin
        check("job_end", 64'(exp_q.size() + out_q.size()), 64'(0));
        exp_q.delete();
        out_q.delete();
      end
    end
    rdy_mode = 0;
    timeout_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
  endtask
  initial begin
    int n;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i = '0;
    cmd_data_i = '0;
    cmd_last_i = 1'b0;
    timeout_i = '0;
    abort_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outs", 64'({cfg_valid_o, cmd_ready_o, busy_o, job_done_o, job_err_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    cmd_a[0] = 5'h00; cmd_d[0] = 32'h100;
    cmd_a[1] = 5'h16; cmd_d[1] = 32'h2;
    cmd_a[2] = 5'h12; cmd_d[2] = 32'h55;
    bincu_val = 32'h1234;
    run_job(3, 30, 0, 0, -1, 0, 0);
    check("basic_result", 64'(result_o), 64'(16'h1234));
    rand_cmds(5);
    bincu_val = $urandom;
    run_job(5, 40, 0, 2, -1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      n = 1 + int'($urandom % 6);
      rand_cmds(n);
      bincu_val = $urandom;
      run_job(n, int'($urandom_range(0, 60)), ($urandom % 2) ? 100 : 0, 1, -1, 0, 0);
    end
    rand_cmds(2);
    run_job(2, NEVER, 4, 1, -1, 0, 0);
    rand_cmds(3);
    run_job(3, NEVER, 0, 0, -1, 1, 0);
    rand_cmds(4);
    bincu_val = $urandom;
    run_job(4, 0, 0, 0, 2, 0, 0);
    rand_cmds(2);
    run_job(2, NEVER, 0, 0, -1, 0, 1);
    rand_cmds(3);
    bincu_val = $urandom;
    run_job(3, 20, 0, 1, -1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
